// File: rtl/exception_ctrl_if.sv
// MEM-stage exception bus between the pipeline/CP0 side (master) and exception_ctrl (slave).
interface exception_ctrl_if;
  logic        valid_mem;
  logic [31:0] pc_mem;
  logic        in_delay_slot;
  logic        int_pending;
  logic        status_exl;
  logic        adel_if;
  logic        ri;
  logic        ov;
  logic        sys;
  logic        bp;
  logic        adel_mem;
  logic        ades_mem;
  logic [31:0] bad_addr;
  logic        eret;
  logic [31:0] epc_q;
  logic        exception_abort;
  logic [4:0]  exception_code;
  logic        bd_p;
  logic        epc_we;
  logic [31:0] epc_data;
  logic        badvaddr_we;
  logic [31:0] badvaddr_data;
  logic        exl_set;
  logic        exl_clr;
  logic        flush;
  logic        busy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport slave (
    input  valid_mem, pc_mem, in_delay_slot, int_pending, status_exl, adel_if, ri, ov, sys, bp,
           adel_mem, ades_mem, bad_addr, eret, epc_q, redirect_ready,
    output exception_abort, exception_code, bd_p, epc_we, epc_data, badvaddr_we, badvaddr_data,
           exl_set, exl_clr, flush, busy, redirect_valid, redirect_pc
  );

  modport master (
    output valid_mem, pc_mem, in_delay_slot, int_pending, status_exl, adel_if, ri, ov, sys, bp,
           adel_mem, ades_mem, bad_addr, eret, epc_q, redirect_ready,
    input  exception_abort, exception_code, bd_p, epc_we, epc_data, badvaddr_we, badvaddr_data,
           exl_set, exl_clr, flush, busy, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/exception_ctrl.sv
// CP0 exception controller: prioritises MEM-stage exceptions/ERET, pulses abort to cause_unit,
// writes EPC/BadVAddr, flushes the pipeline and hands a redirect target to fetch.
module exception_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic              i_clk,
  input logic              i_rst,
  exception_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StAbort, StFlush, StRedirect} state_e;

  state_e      r_state, w_state_nxt;
  logic [4:0]  r_code, w_code_nxt;
  logic        r_bd, w_bd_nxt;
  logic        r_epc_we, w_epc_we_nxt;
  logic [31:0] r_epc_data, w_epc_data_nxt;
  logic        r_bad_we, w_bad_we_nxt;
  logic [31:0] r_bad_data, w_bad_data_nxt;
  logic [31:0] r_redirect_pc, w_redirect_pc_nxt;
  logic [3:0]  r_flush_cnt, w_flush_cnt_nxt;
  logic        r_eret_first, w_eret_first_nxt;

  logic        w_exc;
  logic [4:0]  w_code;
  logic        w_addr_err;

  // Priority encoder; interrupts are masked while EXL is set.
  always_comb begin
    w_exc      = 1'b1;
    w_code     = 5'd0;
    w_addr_err = 1'b0;
    if (!bus.valid_mem) begin
      w_exc = 1'b0;
    end else if (bus.int_pending && !bus.status_exl) begin
      w_code = 5'd0;
    end else if (bus.adel_if) begin
      w_code     = 5'd4;
      w_addr_err = 1'b1;
    end else if (bus.ri) begin
      w_code = 5'd10;
    end else if (bus.ov) begin
      w_code = 5'd12;
    end else if (bus.sys) begin
      w_code = 5'd8;
    end else if (bus.bp) begin
      w_code = 5'd9;
    end else if (bus.adel_mem) begin
      w_code     = 5'd4;
      w_addr_err = 1'b1;
    end else if (bus.ades_mem) begin
      w_code     = 5'd5;
      w_addr_err = 1'b1;
    end else begin
      w_exc = 1'b0;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_code_nxt        = r_code;
    w_bd_nxt          = r_bd;
    w_epc_we_nxt      = r_epc_we;
    w_epc_data_nxt    = r_epc_data;
    w_bad_we_nxt      = r_bad_we;
    w_bad_data_nxt    = r_bad_data;
    w_redirect_pc_nxt = r_redirect_pc;
    w_flush_cnt_nxt   = r_flush_cnt;
    w_eret_first_nxt  = r_eret_first;
    unique case (r_state)
      StIdle: begin
        if (w_exc) begin
          w_state_nxt       = StAbort;
          w_code_nxt        = w_code;
          w_bd_nxt          = bus.in_delay_slot;
          w_epc_we_nxt      = !bus.status_exl;
          w_epc_data_nxt    = bus.in_delay_slot ? bus.pc_mem - 32'd4 : bus.pc_mem;
          w_bad_we_nxt      = w_addr_err;
          w_bad_data_nxt    = bus.adel_if ? bus.pc_mem : bus.bad_addr;
          w_redirect_pc_nxt = EXC_VECTOR;
        end else if (bus.valid_mem && bus.eret) begin
          w_state_nxt       = StRedirect;
          w_redirect_pc_nxt = bus.epc_q;
          w_eret_first_nxt  = 1'b1;
        end
      end
      StAbort: begin
        w_state_nxt     = StFlush;
        w_flush_cnt_nxt = 4'(FLUSH_CYCLES - 1);
      end
      StFlush: begin
        if (r_flush_cnt == 4'd0) begin
          w_state_nxt = StRedirect;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - 4'd1;
        end
      end
      StRedirect: begin
        w_eret_first_nxt = 1'b0;
        if (bus.redirect_ready) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_code        <= 5'd0;
      r_bd          <= 1'b0;
      r_epc_we      <= 1'b0;
      r_epc_data    <= 32'd0;
      r_bad_we      <= 1'b0;
      r_bad_data    <= 32'd0;
      r_redirect_pc <= 32'd0;
      r_flush_cnt   <= 4'd0;
      r_eret_first  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_code        <= w_code_nxt;
      r_bd          <= w_bd_nxt;
      r_epc_we      <= w_epc_we_nxt;
      r_epc_data    <= w_epc_data_nxt;
      r_bad_we      <= w_bad_we_nxt;
      r_bad_data    <= w_bad_data_nxt;
      r_redirect_pc <= w_redirect_pc_nxt;
      r_flush_cnt   <= w_flush_cnt_nxt;
      r_eret_first  <= w_eret_first_nxt;
    end
  end

  // Outputs decode from registered state only; captured data is gated to its valid window.
  always_comb begin
    bus.exception_abort = (r_state == StAbort);
    bus.exception_code  = (r_state == StAbort) ? r_code : 5'd0;
    bus.bd_p            = (r_state == StAbort) && r_bd;
    bus.epc_we          = (r_state == StAbort) && r_epc_we;
    bus.epc_data        = (r_state == StAbort) ? r_epc_data : 32'd0;
    bus.badvaddr_we     = (r_state == StAbort) && r_bad_we;
    bus.badvaddr_data   = (r_state == StAbort) ? r_bad_data : 32'd0;
    bus.exl_set         = (r_state == StAbort);
    bus.exl_clr         = (r_state == StRedirect) && r_eret_first;
    bus.flush           = (r_state == StFlush) || ((r_state == StRedirect) && r_eret_first);
    bus.busy            = (r_state != StIdle);
    bus.redirect_valid  = (r_state == StRedirect);
    bus.redirect_pc     = (r_state == StRedirect) ? r_redirect_pc : 32'd0;
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// Bench for exception_ctrl: directed cases plus randomized transactions against a priority model.
module tb_exception_ctrl;
  localparam logic [31:0] ExcVector = 32'hBFC0_0380;
  localparam int          Fc        = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exception_ctrl_if bus ();

  exception_ctrl #(
    .EXC_VECTOR  (ExcVector),
    .FLUSH_CYCLES(Fc)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.valid_mem      = 1'b0;
    bus.pc_mem         = 32'd0;
    bus.in_delay_slot  = 1'b0;
    bus.int_pending    = 1'b0;
    bus.status_exl     = 1'b0;
    bus.adel_if        = 1'b0;
    bus.ri             = 1'b0;
    bus.ov             = 1'b0;
    bus.sys            = 1'b0;
    bus.bp             = 1'b0;
    bus.adel_mem       = 1'b0;
    bus.ades_mem       = 1'b0;
    bus.bad_addr       = 32'd0;
    bus.eret           = 1'b0;
    bus.epc_q          = 32'd0;
    bus.redirect_ready = 1'b0;
  endtask

  // Flags thrown at the DUT while it is busy; all must be ignored.
  task automatic noise();
    bus.valid_mem   = 1'b1;
    bus.ov          = 1'($urandom);
    bus.eret        = 1'($urandom);
    bus.int_pending = 1'($urandom);
    bus.ades_mem    = 1'($urandom);
    bus.pc_mem      = $urandom;
    bus.epc_q       = $urandom;
  endtask

  // Priority list walked in order; first raised flag wins.
  function automatic void model(output bit exc, output logic [4:0] code, output bit badv);
    bit         f[8];
    logic [4:0] c[8];
    c = '{5'd0, 5'd4, 5'd10, 5'd12, 5'd8, 5'd9, 5'd4, 5'd5};
    f = '{bus.int_pending && !bus.status_exl, bus.adel_if, bus.ri, bus.ov, bus.sys, bus.bp,
          bus.adel_mem, bus.ades_mem};
    exc  = 1'b0;
    code = 5'd0;
    if (bus.valid_mem) begin
      for (int i = 0; i < 8; i++) begin
        if (f[i] && !exc) begin
          exc  = 1'b1;
          code = c[i];
        end
      end
    end
    badv = exc && (code == 5'd4 || code == 5'd5);
  endfunction

  // Inputs for the detect cycle are already on the bus; runs until back in idle.
  task automatic do_txn(input int rdly);
    bit          exc, badv, is_eret, epcwe;
    logic [4:0]  code;
    logic [31:0] epc_exp, bad_exp, tgt;
    model(exc, code, badv);
    is_eret = !exc && bus.valid_mem && bus.eret;
    epcwe   = !bus.status_exl;
    epc_exp = bus.in_delay_slot ? bus.pc_mem - 32'd4 : bus.pc_mem;
    bad_exp = bus.adel_if ? bus.pc_mem : bus.bad_addr;
    tgt     = exc ? ExcVector : bus.epc_q;
    chk1("idle_before", bus.busy, 1'b0);
    if (exc) begin
      logic bd;
      bd = bus.in_delay_slot;
      step();
      noise();
      chk1("abort", bus.exception_abort, 1'b1);
      chk32("code", 32'(bus.exception_code), 32'(code));
      chk1("bd_p", bus.bd_p, bd);
      chk1("epc_we", bus.epc_we, epcwe);
      if (epcwe) chk32("epc_data", bus.epc_data, epc_exp);
      chk1("badvaddr_we", bus.badvaddr_we, badv);
      if (badv) chk32("badvaddr_data", bus.badvaddr_data, bad_exp);
      chk1("exl_set", bus.exl_set, 1'b1);
      chk1("abort_flush", bus.flush, 1'b0);
      chk1("abort_rv", bus.redirect_valid, 1'b0);
      for (int k = 0; k < Fc; k++) begin
        step();
        noise();
        chk1("flush", bus.flush, 1'b1);
        chk1("flush_abort", bus.exception_abort, 1'b0);
        chk1("flush_rv", bus.redirect_valid, 1'b0);
        chk1("flush_busy", bus.busy, 1'b1);
      end
      step();
      noise();
    end else if (is_eret) begin
      step();
      noise();
    end else begin
      step();
      chk1("none_abort", bus.exception_abort, 1'b0);
      chk1("none_busy", bus.busy, 1'b0);
      clear_in();
      return;
    end
    for (int k = 0; k <= rdly; k++) begin
      bus.redirect_ready = (k == rdly);
      chk1("rv", bus.redirect_valid, 1'b1);
      chk32("rpc", bus.redirect_pc, tgt);
      chk1("rd_abort", bus.exception_abort, 1'b0);
      chk1("rd_exl_set", bus.exl_set, 1'b0);
      chk1("exl_clr", bus.exl_clr, is_eret && k == 0);
      chk1("rd_flush", bus.flush, is_eret && k == 0);
      step();
      noise();
    end
    bus.redirect_ready = 1'b0;
    chk1("rv_drop", bus.redirect_valid, 1'b0);
    chk1("back_idle", bus.busy, 1'b0);
    clear_in();
  endtask

  task automatic chk_all_zero(input string tag);
    logic any;
    any = bus.exception_abort | (|bus.exception_code) | bus.bd_p | bus.epc_we | (|bus.epc_data)
        | bus.badvaddr_we | (|bus.badvaddr_data) | bus.exl_set | bus.exl_clr | bus.flush
        | bus.busy | bus.redirect_valid | (|bus.redirect_pc);
    chk1(tag, any, 1'b0);
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    step();
    step();
    chk_all_zero("reset_outputs");
    rst = 1'b0;

    // Overflow, not in a delay slot.
    bus.valid_mem = 1'b1; bus.ov = 1'b1; bus.pc_mem = 32'h0040_0010;
    do_txn(0);

    // Syscall in a delay slot.
    bus.valid_mem = 1'b1; bus.sys = 1'b1; bus.in_delay_slot = 1'b1; bus.pc_mem = 32'h0040_0024;
    do_txn(1);

    // Interrupt beats RI; with EXL set RI wins and EPC is not written.
    bus.valid_mem = 1'b1; bus.int_pending = 1'b1; bus.ri = 1'b1; bus.pc_mem = 32'h0040_0030;
    do_txn(0);
    bus.valid_mem = 1'b1; bus.int_pending = 1'b1; bus.ri = 1'b1; bus.status_exl = 1'b1;
    bus.pc_mem = 32'h0040_0034;
    do_txn(0);

    // Store address error.
    bus.valid_mem = 1'b1; bus.ades_mem = 1'b1; bus.bad_addr = 32'h1000_0003;
    bus.pc_mem = 32'h0040_0040;
    do_txn(2);

    // Fetch address error uses the PC as BadVAddr.
    bus.valid_mem = 1'b1; bus.adel_if = 1'b1; bus.adel_mem = 1'b1; bus.bad_addr = 32'h2000_0001;
    bus.pc_mem = 32'h0040_0051;
    do_txn(0);

    // ERET with fetch stalling three cycles.
    bus.valid_mem = 1'b1; bus.eret = 1'b1; bus.epc_q = 32'h0040_0100;
    do_txn(3);

    // Exception wins over ERET in the same cycle.
    bus.valid_mem = 1'b1; bus.eret = 1'b1; bus.bp = 1'b1; bus.epc_q = 32'h0040_0200;
    bus.pc_mem = 32'h0040_0060;
    do_txn(0);

    // EPC wraps below zero for a delay-slot instruction at address 0.
    bus.valid_mem = 1'b1; bus.ov = 1'b1; bus.in_delay_slot = 1'b1; bus.pc_mem = 32'h0000_0000;
    do_txn(0);

    // Flags without valid_mem are ignored.
    bus.valid_mem = 1'b0; bus.ov = 1'b1; bus.eret = 1'b1;
    do_txn(0);

    // Reset while flushing drops the transaction.
    bus.valid_mem = 1'b1; bus.ov = 1'b1; bus.pc_mem = 32'h0040_0070;
    step();
    clear_in();
    chk1("pre_rst_abort", bus.exception_abort, 1'b1);
    step();
    chk1("pre_rst_flush", bus.flush, 1'b1);
    rst = 1'b1;
    step();
    chk_all_zero("rst_in_flush");
    rst = 1'b0;
    step();
    chk_all_zero("after_rst_idle");

    for (int n = 0; n < 60; n++) begin
      bus.valid_mem     = ($urandom_range(0, 7) != 0);
      bus.pc_mem        = $urandom;
      bus.in_delay_slot = 1'($urandom);
      bus.status_exl    = 1'($urandom);
      bus.int_pending   = ($urandom_range(0, 5) == 0);
      bus.adel_if       = ($urandom_range(0, 7) == 0);
      bus.ri            = ($urandom_range(0, 7) == 0);
      bus.ov            = ($urandom_range(0, 7) == 0);
      bus.sys           = ($urandom_range(0, 7) == 0);
      bus.bp            = ($urandom_range(0, 7) == 0);
      bus.adel_mem      = ($urandom_range(0, 7) == 0);
      bus.ades_mem      = ($urandom_range(0, 7) == 0);
      bus.bad_addr      = $urandom;
      bus.eret          = ($urandom_range(0, 3) == 0);
      bus.epc_q         = $urandom;
      do_txn(int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
